reset_sequencer: RTL and testbench

//  Converts the active-high synchronous system reset into a registered, stretched

---
 rtl/reset_seq_pkg.sv | 17 +
 rtl/reset_seq_cnt.sv | 22 ++
 rtl/reset_sequencer.sv | 105 ++++++++++
 tb/tb_reset_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared definitions for the reset sequencer: state encoding and counter sizing.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_SWA  = 2'd2
  } state_t;

  // Width needed to hold the larger of the two delay loads.
  function automatic int cnt_width(input int rst_delay, input int sw_hold);
    int m;
    m = (rst_delay > sw_hold) ? rst_delay : sw_hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_seq_cnt.sv
// Loadable down-counter; load wins over dec, and it never wraps below zero.
module reset_seq_cnt #(
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge CLK) begin
    if (load)
      cnt <= load_val;
    else if (dec && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// Stretches the platform reset into a registered active-low reset and adds a
// software-requested reset with a REQ/ACK handshake.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int RSTDELAY = 15,
  parameter int SWHOLD   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic SW_RST_REQ,
  output logic SW_RST_ACK,
  output logic RESET_OUT_N,
  output logic RESET_DONE
);

  localparam int CW = cnt_width(RSTDELAY, SWHOLD);
  localparam logic [CW-1:0] RST_LOAD = CW'(RSTDELAY);
  localparam logic [CW-1:0] SW_LOAD  = CW'(SWHOLD - 1);

  state_t        state, state_d;
  logic          sw_pend, pend_d;
  logic          out_n_d, done_d, ack_d;
  logic          load, dec, zero;
  logic [CW-1:0] load_val, cnt;

  reset_seq_cnt #(.CW(CW)) u_cnt (
    .CLK      (CLK),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .cnt      (cnt),
    .zero     (zero)
  );

  always_comb begin
    state_d  = state;
    pend_d   = sw_pend;
    out_n_d  = RESET_OUT_N;
    done_d   = 1'b0;
    ack_d    = 1'b0;
    load     = 1'b0;
    load_val = RST_LOAD;
    dec      = 1'b0;
    if (RST) begin
      load = 1'b1;
    end else begin
      case (state)
        ST_HOLD: begin
          if (!zero) begin
            dec = 1'b1;
          end else begin
            state_d = ST_RUN;
            out_n_d = 1'b1;
            done_d  = 1'b1;
            ack_d   = sw_pend;
            pend_d  = 1'b0;
          end
        end
        // Ignoring REQ while ACK is high keeps a requester that drops REQ on ACK
        // from retriggering.
        ST_RUN: begin
          if (SW_RST_REQ && !SW_RST_ACK) begin
            state_d  = ST_SWA;
            load     = 1'b1;
            load_val = SW_LOAD;
            out_n_d  = 1'b0;
            pend_d   = 1'b1;
          end
        end
        ST_SWA: begin
          if (!zero) begin
            dec = 1'b1;
          end else begin
            state_d = ST_HOLD;
            load    = 1'b1;
          end
        end
        default: begin
          state_d = ST_HOLD;
          load    = 1'b1;
          out_n_d = 1'b0;
          pend_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_HOLD;
      sw_pend     <= 1'b0;
      RESET_OUT_N <= 1'b0;
      RESET_DONE  <= 1'b0;
      SW_RST_ACK  <= 1'b0;
    end else begin
      state       <= state_d;
      sw_pend     <= pend_d;
      RESET_OUT_N <= out_n_d;
      RESET_DONE  <= done_d;
      SW_RST_ACK  <= ack_d;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed checks of the reset sequencer (RSTDELAY=4, SWHOLD=3) plus a randomized
// property check on a RSTDELAY=1, SWHOLD=1 instance.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, req = 1'b0;
  logic ack, out_n, done;
  logic rst2 = 1'b1, req2 = 1'b0;
  logic ack2, out_n2, done2;

  int checks = 0;
  int errors = 0;

  reset_sequencer #(.RSTDELAY(4), .SWHOLD(3)) dut (
    .CLK(clk), .RST(rst), .SW_RST_REQ(req),
    .SW_RST_ACK(ack), .RESET_OUT_N(out_n), .RESET_DONE(done)
  );

  reset_sequencer #(.RSTDELAY(1), .SWHOLD(1)) dut2 (
    .CLK(clk), .RST(rst2), .SW_RST_REQ(req2),
    .SW_RST_ACK(ack2), .RESET_OUT_N(out_n2), .RESET_DONE(done2)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0;
    repeat (3) step();
    checks++;
    if ({out_n, done, ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got out_n/done/ack=%b expected 000", {out_n, done, ack});
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if ({out_n, done, ack} !== {k >= 5, k == 5, 1'b0}) begin
        errors++;
        $display("FAIL reset_release k=%0d: got out_n/done/ack=%b expected %b",
                 k, {out_n, done, ack}, {k >= 5, k == 5, 1'b0});
      end
    end
  endtask

  task automatic test_sw_req();
    req = 1'b1;
    for (int i = 1; i <= 13; i++) begin
      step();
      checks++;
      if ({out_n, done, ack} !== {(i >= 9), (i == 9), (i == 9)}) begin
        errors++;
        $display("FAIL sw_req i=%0d: got out_n/done/ack=%b expected %b",
                 i, {out_n, done, ack}, {(i >= 9), (i == 9), (i == 9)});
      end
      if (ack) req = 1'b0;
    end
    req = 1'b0;
  endtask

  task automatic test_sw_hold_req();
    req = 1'b1;
    for (int i = 1; i <= 19; i++) begin
      step();
      checks++;
      if ({out_n, ack} !== {(i >= 9 && i <= 10) || i == 19, (i == 9 || i == 19)}) begin
        errors++;
        $display("FAIL sw_hold_req i=%0d: got out_n/ack=%b expected %b", i, {out_n, ack},
                 {(i >= 9 && i <= 10) || i == 19, (i == 9 || i == 19)});
      end
      if (i == 11) req = 1'b0;
    end
  endtask

  task automatic test_rst_mid_swa();
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    step();
    checks++;
    if (out_n !== 1'b0) begin
      errors++;
      $display("FAIL mid_swa_entry: got out_n=%b expected 0", out_n);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if ({out_n, done, ack} !== {k >= 5, k == 5, 1'b0}) begin
        errors++;
        $display("FAIL rst_mid_swa k=%0d: got out_n/done/ack=%b expected %b",
                 k, {out_n, done, ack}, {k >= 5, k == 5, 1'b0});
      end
    end
  endtask

  task automatic test_rst_in_hold();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if ({out_n, done} !== {k >= 5, k == 5}) begin
        errors++;
        $display("FAIL rst_in_hold k=%0d: got out_n/done=%b expected %b",
                 k, {out_n, done}, {k >= 5, k == 5});
      end
    end
  endtask

  task automatic test_corner_random();
    int  since_rst;
    bit  pend;
    bit  prev_out;
    bit  rst_applied;
    rst2 = 1'b1;
    step();
    since_rst = 0; pend = 1'b0; prev_out = out_n2;
    for (int c = 0; c < 600; c++) begin
      rst2 = ($urandom_range(0, 24) == 0);
      req2 = ($urandom_range(0, 3) != 0);
      rst_applied = rst2;
      step();
      if (rst_applied) begin
        since_rst = 0;
        pend = 1'b0;
      end else begin
        since_rst++;
      end
      if (prev_out && !out_n2 && !rst_applied) pend = 1'b1;
      if (!prev_out && out_n2) begin
        checks++;
        if (since_rst < 2) begin
          errors++;
          $display("FAIL corner_low_time c=%0d: got %0d edges expected >= 2", c, since_rst);
        end
        checks++;
        if ({done2, ack2} !== {1'b1, pend}) begin
          errors++;
          $display("FAIL corner_release c=%0d: got done/ack=%b expected %b",
                   c, {done2, ack2}, {1'b1, pend});
        end
        pend = 1'b0;
      end else begin
        checks++;
        if ({done2, ack2} !== 2'b00) begin
          errors++;
          $display("FAIL corner_no_pulse c=%0d: got done/ack=%b expected 00", c, {done2, ack2});
        end
      end
      prev_out = out_n2;
    end
    rst2 = 1'b0; req2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sw_req();
    test_sw_hold_req();
    test_rst_mid_swa();
    test_rst_in_hold();
    test_corner_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
